// File: rtl/adbg_jtag_tap.sv
// JTAG TAP controller, instruction register and TDO mux for the advanced debug interface.
// Latency: state strobes decode the registered state (no extra cycle); TDO is re-timed onto the falling edge of tck_i.
// Backpressure: none; the JTAG host paces everything through tck_i/tms_i.
module adbg_jtag_tap #(
    parameter int                 IR_LEN       = 4,
    parameter logic [31:0]        IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_LEN-1:0]  IDCODE_INSTR = 4'b0010,
    parameter logic [IR_LEN-1:0]  DEBUG_INSTR  = 4'b1000,
    parameter logic [IR_LEN-1:0]  BYPASS_INSTR = 4'b1111
) (
    input  logic tck_i,
    input  logic trstn_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic test_logic_reset_o,
    output logic run_test_idle_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic debug_select_o
);

    // TAP state encoding (16 standard 1149.1 states)
    localparam logic [3:0] ST_TLR      = 4'd0;
    localparam logic [3:0] ST_RTI      = 4'd1;
    localparam logic [3:0] ST_SEL_DR   = 4'd2;
    localparam logic [3:0] ST_CAP_DR   = 4'd3;
    localparam logic [3:0] ST_SHIFT_DR = 4'd4;
    localparam logic [3:0] ST_EXIT1_DR = 4'd5;
    localparam logic [3:0] ST_PAUSE_DR = 4'd6;
    localparam logic [3:0] ST_EXIT2_DR = 4'd7;
    localparam logic [3:0] ST_UPD_DR   = 4'd8;
    localparam logic [3:0] ST_SEL_IR   = 4'd9;
    localparam logic [3:0] ST_CAP_IR   = 4'd10;
    localparam logic [3:0] ST_SHIFT_IR = 4'd11;
    localparam logic [3:0] ST_EXIT1_IR = 4'd12;
    localparam logic [3:0] ST_PAUSE_IR = 4'd13;
    localparam logic [3:0] ST_EXIT2_IR = 4'd14;
    localparam logic [3:0] ST_UPD_IR   = 4'd15;

    // IR capture pattern: ...0001, the mandatory '01' in the two LSBs
    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-1){1'b0}}, 1'b1};

    logic [3:0]        state_q, state_d;
    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
    logic [IR_LEN-1:0] ir_latched_q, ir_latched_d;
    logic              debug_select_q, debug_select_d;
    logic [31:0]       idcode_q, idcode_d;
    logic              bypass_q, bypass_d;
    logic              tdo_q, tdo_d;
    logic              tdo_oe_q, tdo_oe_d;

    // State decodes shared by the datapath and the outputs
    logic in_tlr, in_cap_dr, in_shift_dr, in_cap_ir, in_shift_ir, in_upd_ir;
    assign in_tlr      = (state_q == ST_TLR);
    assign in_cap_dr   = (state_q == ST_CAP_DR);
    assign in_shift_dr = (state_q == ST_SHIFT_DR);
    assign in_cap_ir   = (state_q == ST_CAP_IR);
    assign in_shift_ir = (state_q == ST_SHIFT_IR);
    assign in_upd_ir   = (state_q == ST_UPD_IR);

    // Instruction decode; anything not IDCODE or DEBUG falls back to BYPASS
    logic sel_idcode, sel_debug, sel_bypass;
    assign sel_idcode = (ir_latched_q == IDCODE_INSTR);
    assign sel_debug  = (ir_latched_q == DEBUG_INSTR);
    assign sel_bypass = (ir_latched_q == BYPASS_INSTR) || !(sel_idcode || sel_debug);

    // TAP next-state from TMS
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TLR:      state_d = tms_i ? ST_TLR      : ST_RTI;
            ST_RTI:      state_d = tms_i ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_d = tms_i ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_d = tms_i ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_d = tms_i ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_d = tms_i ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_d = tms_i ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_d = tms_i ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_d = tms_i ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_d = tms_i ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_d = tms_i ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_d = tms_i ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_d = tms_i ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_d = tms_i ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_d = tms_i ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_d = tms_i ? ST_SEL_DR   : ST_RTI;
            default:     state_d = ST_TLR;
        endcase
    end

    // Instruction register: capture/shift stage plus the latched instruction.
    // Only Update-IR changes the active instruction; a scan aborted by reset is lost.
    always_comb begin
        ir_shift_d   = ir_shift_q;
        ir_latched_d = ir_latched_q;
        if (in_cap_ir) begin
            ir_shift_d = IR_CAPTURE;
        end else if (in_shift_ir) begin
            ir_shift_d = {tdi_i, ir_shift_q[IR_LEN-1:1]};
        end
        if (in_tlr) begin
            ir_latched_d = IDCODE_INSTR;
        end else if (in_upd_ir) begin
            ir_latched_d = ir_shift_q;
        end
        debug_select_d = (ir_latched_d == DEBUG_INSTR);
    end

    // Internal data registers; with DEBUG selected the debug modules own the DR
    always_comb begin
        idcode_d = idcode_q;
        bypass_d = bypass_q;
        if (in_cap_dr) begin
            bypass_d = 1'b0;
            if (sel_idcode) begin
                idcode_d = IDCODE_VALUE;
            end
        end else if (in_shift_dr) begin
            if (sel_idcode) begin
                idcode_d = {tdi_i, idcode_q[31:1]};
            end
            if (sel_bypass) begin
                bypass_d = tdi_i;
            end
        end
    end

    // TDO source select, sampled on the falling edge
    always_comb begin
        tdo_oe_d = in_shift_ir || in_shift_dr;
        tdo_d    = 1'b0;
        if (in_shift_ir) begin
            tdo_d = ir_shift_q[0];
        end else if (in_shift_dr) begin
            if (sel_idcode) begin
                tdo_d = idcode_q[0];
            end else if (sel_debug) begin
                tdo_d = debug_tdo_i;
            end else begin
                tdo_d = bypass_q;
            end
        end
    end

    // Rising-edge state: TAP state, IR and internal DRs
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            state_q        <= ST_TLR;
            ir_shift_q     <= '0;
            ir_latched_q   <= IDCODE_INSTR;
            debug_select_q <= 1'b0;
            idcode_q       <= '0;
            bypass_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            ir_shift_q     <= ir_shift_d;
            ir_latched_q   <= ir_latched_d;
            debug_select_q <= debug_select_d;
            idcode_q       <= idcode_d;
            bypass_q       <= bypass_d;
        end
    end

    // Falling-edge TDO retiming so data is stable around the host's rising-edge sample
    always_ff @(negedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign tdo_o              = tdo_q;
    assign tdo_oe_o           = tdo_oe_q;
    assign debug_select_o     = debug_select_q;
    assign test_logic_reset_o = in_tlr;
    assign run_test_idle_o    = (state_q == ST_RTI);
    assign capture_dr_o       = in_cap_dr;
    assign shift_dr_o         = in_shift_dr;
    assign pause_dr_o         = (state_q == ST_PAUSE_DR);
    assign update_dr_o        = (state_q == ST_UPD_DR);

endmodule

// File: tb/tb_adbg_jtag_tap.sv
// Directed bench for adbg_jtag_tap: drives TMS/TDI after each falling edge, samples 1 ns later.
// Latency: state strobes and TDO are both observed half a TCK period after the rising edge.
// Backpressure: none.
module tb_adbg_jtag_tap;

    logic tck_i = 1'b0;
    logic trstn_i, tms_i, tdi_i, debug_tdo_i;
    logic tdo_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o;
    logic capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o, debug_select_o;

    int checks = 0;
    int errors = 0;
    logic in_ir_scan = 1'b0;
    logic dr_strobe_seen = 1'b0;

    adbg_jtag_tap dut (
        .tck_i              (tck_i),
        .trstn_i            (trstn_i),
        .tms_i              (tms_i),
        .tdi_i              (tdi_i),
        .tdo_o              (tdo_o),
        .tdo_oe_o           (tdo_oe_o),
        .debug_tdo_i        (debug_tdo_i),
        .test_logic_reset_o (test_logic_reset_o),
        .run_test_idle_o    (run_test_idle_o),
        .capture_dr_o       (capture_dr_o),
        .shift_dr_o         (shift_dr_o),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o),
        .debug_select_o     (debug_select_o)
    );

    always #5 tck_i = ~tck_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One TCK cycle: present tms/tdi, take the rising edge, sample after the falling edge
    task automatic step(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge tck_i);
        @(negedge tck_i);
        #1;
        if (in_ir_scan && (capture_dr_o || shift_dr_o || pause_dr_o || update_dr_o))
            dr_strobe_seen = 1'b1;
    endtask

    task automatic goto_tlr();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    endtask

    // IR scan from RTI back to RTI; returns the captured bits seen on TDO
    task automatic ir_scan(input logic [3:0] instr, output logic [3:0] dout);
        in_ir_scan = 1'b1;
        step(1'b1, 1'b0);          // SEL_DR
        step(1'b1, 1'b0);          // SEL_IR
        step(1'b0, 1'b0);          // CAP_IR
        step(1'b0, 1'b0);          // SHIFT_IR
        dout[0] = tdo_o;
        for (int i = 0; i < 4; i++) begin
            step(i == 3, instr[i]);
            if (i < 3) dout[i+1] = tdo_o;
        end
        step(1'b1, 1'b0);          // UPD_IR
        step(1'b0, 1'b0);          // RTI
        in_ir_scan = 1'b0;
    endtask

    // DR scan of n bits from RTI back to RTI
    task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        step(1'b1, 1'b0);          // SEL_DR
        step(1'b0, 1'b0);          // CAP_DR
        step(1'b0, 1'b0);          // SHIFT_DR
        dout[0] = tdo_o;
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i]);
            if (i < n - 1) dout[i+1] = tdo_o;
        end
        step(1'b1, 1'b0);          // UPD_DR
        step(1'b0, 1'b0);          // RTI
    endtask

    logic [31:0] pat;
    logic [31:0] bits;
    logic [3:0]  ir_out;
    logic [63:0] dr_out;
    logic [15:0] paths [6];
    int          plen  [6];

    initial begin
        pat = 32'hA5C3_0F96;
        trstn_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0; debug_tdo_i = 1'b0;
        #12;
        check("rst_tlr", test_logic_reset_o, 1);
        check("rst_strobes", {run_test_idle_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o}, 0);
        check("rst_tdo", {tdo_o, tdo_oe_o, debug_select_o}, 0);
        @(negedge tck_i); #1;
        trstn_i = 1'b1;

        // IDCODE readout straight after reset
        step(1'b0, 1'b0);
        check("rti", run_test_idle_o, 1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("cap_dr", capture_dr_o, 1);
        check("cap_dr_oe", tdo_oe_o, 0);
        step(1'b0, 1'b0);
        check("shift_dr_oe", {shift_dr_o, tdo_oe_o}, 2'b11);
        bits[0] = tdo_o;
        for (int k = 1; k < 32; k++) begin
            step(1'b0, pat[k-1]);
            bits[k] = tdo_o;
        end
        check("idcode", bits, 32'h149511C3);
        step(1'b0, pat[31]);
        check("bit33", tdo_o, pat[0]);
        goto_tlr();
        check("tlr_from_shift_dr", {test_logic_reset_o, tdo_oe_o}, 2'b10);
        step(1'b0, 1'b0);

        // BYPASS via explicit opcode
        ir_scan(4'b1111, ir_out);
        check("ir_capture", ir_out, 4'b0001);
        check("ir_no_dr_strobe", dr_strobe_seen, 0);
        dr_scan(4, 64'b1101, dr_out);
        check("bypass_1011", dr_out[3:0], 4'b1010);

        // DEBUG instruction: strobes and debug TDO passthrough
        ir_scan(4'b1000, ir_out);
        check("debug_sel", debug_select_o, 1);
        step(1'b1, 1'b0);
        check("sel_dr_no_cap", capture_dr_o, 0);
        step(1'b0, 1'b0);
        check("dbg_cap", {capture_dr_o, shift_dr_o}, 2'b10);
        debug_tdo_i = 1'b1;
        step(1'b0, 1'b0);
        check("dbg_shift", {capture_dr_o, shift_dr_o}, 2'b01);
        check("dbg_tdo1", tdo_o, 1);
        debug_tdo_i = 1'b0;
        #2;
        check("dbg_tdo_hold", tdo_o, 1);
        step(1'b0, 1'b0);
        check("dbg_tdo0", tdo_o, 0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("dbg_pause", {pause_dr_o, shift_dr_o, tdo_oe_o}, 3'b100);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("dbg_update", update_dr_o, 1);
        step(1'b0, 1'b0);
        check("dbg_rti", {run_test_idle_o, update_dr_o, debug_select_o}, 3'b101);

        // Unknown opcode behaves as BYPASS
        ir_scan(4'b0101, ir_out);
        check("unk_no_debug", debug_select_o, 0);
        dr_scan(4, 64'b0110, dr_out);
        check("unk_bypass", dr_out[3:0], 4'b1100);

        // PAUSE_IR then five TMS=1; IR must reload IDCODE
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        goto_tlr();
        check("tlr_from_pause_ir", test_logic_reset_o, 1);
        step(1'b0, 1'b0);
        dr_scan(32, 64'h0, dr_out);
        check("ir_reload_idcode", dr_out[31:0], 32'h149511C3);

        // Five TMS=1 from several other states (paths from RTI, LSB first)
        paths[0] = 16'b0;     plen[0] = 0;   // RTI
        paths[1] = 16'b1;     plen[1] = 1;   // SEL_DR
        paths[2] = 16'b011;   plen[2] = 3;   // CAP_IR
        paths[3] = 16'b10101; plen[3] = 5;   // EXIT2_DR
        paths[4] = 16'b11011; plen[4] = 5;   // UPD_IR
        paths[5] = 16'b00101; plen[5] = 5;   // PAUSE_DR
        for (int p = 0; p < 6; p++) begin
            ir_scan(4'b1111, ir_out);
            for (int j = 0; j < plen[p]; j++) step(paths[p][j], 1'b0);
            goto_tlr();
            check($sformatf("tlr_path%0d", p), test_logic_reset_o, 1);
            step(1'b0, 1'b0);
        end

        // Reset mid SHIFT_IR after two bits, with DEBUG active beforehand
        ir_scan(4'b1000, ir_out);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        check("mid_shift_oe", tdo_oe_o, 1);
        #2;
        trstn_i = 1'b0;
        #1;
        check("arst_tdo", {tdo_o, tdo_oe_o, debug_select_o}, 0);
        check("arst_state", {test_logic_reset_o, run_test_idle_o, capture_dr_o,
                             shift_dr_o, pause_dr_o, update_dr_o}, 6'b100000);
        @(negedge tck_i); #1;
        trstn_i = 1'b1;
        step(1'b0, 1'b0);
        dr_scan(32, 64'h0, dr_out);
        check("arst_ir_idcode", dr_out[31:0], 32'h149511C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
